// File: rtl/writeback_scoreboard_pkg.sv
// Shared processor definitions for the writeback scoreboard: register-index
// width, result width, default sizes and the pending-write entry layout.
package writeback_scoreboard_pkg;

  localparam int REG_W     = 5;
  localparam int NUM_REGS  = 32;
  localparam int DATA_W    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 2;

  // One pending register-file write: destination index plus value.
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/writeback_scoreboard_wb_fifo.sv
// Pending-write FIFO: holds accepted results in arrival order until the
// scoreboard retires them, one per cycle. Full/empty come from registered
// occupancy only, so a same-cycle pop never frees a slot for a push.
module wb_fifo
  import writeback_scoreboard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  wb_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_W'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    occ_d    = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
  end

  // Control state: cleared asynchronously, which discards every pending entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage; contents are meaningless until occupancy says otherwise.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/writeback_scoreboard.sv
// Writeback scoreboard: tracks in-flight writes per architectural register
// with saturating counters, buffers returning results in a small FIFO and
// retires them to the register file one per cycle in acceptance order.
module writeback_scoreboard
  import writeback_scoreboard_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IssueValid,
  input  logic [REG_W-1:0]  IssueReg,
  output logic              IssueReady,
  input  logic              ResultValid,
  input  logic [REG_W-1:0]  ResultReg,
  input  logic [DATA_W-1:0] ResultData,
  output logic              ResultReady,
  input  logic [REG_W-1:0]  CheckReg1,
  input  logic [REG_W-1:0]  CheckReg2,
  output logic              Hazard,
  output logic [REG_W-1:0]  WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              WriteEnable
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic              wr_en_q, wr_en_d;
  logic [REG_W-1:0]  wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              issue_fire;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  wb_entry_t         push_data;
  wb_entry_t         head;

  // Register 0 is hardwired: its issues are accepted but never counted and
  // its results are accepted but never queued, so cnt_q[0] stays zero.
  assign IssueReady  = (cnt_q[IssueReg] != CNT_MAX);
  assign issue_fire  = IssueValid & IssueReady & (IssueReg != '0);
  assign ResultReady = ~fifo_full;
  assign push        = ResultValid & ResultReady & (ResultReg != '0);
  assign pop         = ~fifo_empty;
  assign push_data   = '{rd: ResultReg, data: ResultData};
  assign Hazard      = (cnt_q[CheckReg1] != '0) | (cnt_q[CheckReg2] != '0);

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_wb_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Counter update: an issue and a retire of the same register cancel out;
  // a retire of a register with nothing in flight leaves it at zero.
  always_comb begin
    cnt_d[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      logic inc;
      logic dec;
      inc      = issue_fire && (IssueReg == REG_W'(i));
      dec      = pop && (head.rd == REG_W'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Output register: load the FIFO head whenever one is available, else hold.
  always_comb begin
    wr_en_d   = pop;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_reg_d  = head.rd;
      wr_data_d = head.data;
    end
  end

  // Scoreboard and writeback state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign WriteEnable   = wr_en_q;
  assign WriteRegister = wr_reg_q;
  assign WriteData     = wr_data_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Bench for writeback_scoreboard: directed scenarios followed by random
// traffic, all compared against a queue-and-counter reference model.
module tb_writeback_scoreboard;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IssueValid = 1'b0;
  logic [4:0]  IssueReg = '0;
  logic        IssueReady;
  logic        ResultValid = 1'b0;
  logic [4:0]  ResultReg = '0;
  logic [31:0] ResultData = '0;
  logic        ResultReady;
  logic [4:0]  CheckReg1 = '0;
  logic [4:0]  CheckReg2 = '0;
  logic        Hazard;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        WriteEnable;

  writeback_scoreboard #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .IssueValid   (IssueValid),
    .IssueReg     (IssueReg),
    .IssueReady   (IssueReady),
    .ResultValid  (ResultValid),
    .ResultReg    (ResultReg),
    .ResultData   (ResultData),
    .ResultReady  (ResultReady),
    .CheckReg1    (CheckReg1),
    .CheckReg2    (CheckReg2),
    .Hazard       (Hazard),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .WriteEnable  (WriteEnable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight count per register, pending writes in order,
  // and the last write presented to the register file.
  int          cnt_m [32];
  logic [36:0] pend_m [$];
  logic        we_m;
  logic [4:0]  wr_m;
  logic [31:0] wd_m;
  logic [31:0] data_v [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    pend_m.delete();
    we_m = 1'b0;
    wr_m = '0;
    wd_m = '0;
  endfunction

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    bit          ir, rr, hz, ret, iss, same;
    logic [36:0] e;
    #1;
    ir = (cnt_m[IssueReg] != CMAX);
    rr = (pend_m.size() < DEPTH);
    hz = (cnt_m[CheckReg1] != 0) || (cnt_m[CheckReg2] != 0);
    chk("IssueReady", 32'(IssueReady), 32'(ir));
    chk("ResultReady", 32'(ResultReady), 32'(rr));
    chk("Hazard", 32'(Hazard), 32'(hz));
    iss = IssueValid && ir && (IssueReg != 0);
    ret = (pend_m.size() != 0);
    e   = '0;
    if (ret) begin
      e    = pend_m.pop_front();
      we_m = 1'b1;
      wr_m = e[36:32];
      wd_m = e[31:0];
    end else begin
      we_m = 1'b0;
    end
    same = ret && iss && (e[36:32] == IssueReg);
    if (!same) begin
      if (iss) cnt_m[IssueReg]++;
      if (ret && cnt_m[e[36:32]] > 0) cnt_m[e[36:32]]--;
    end
    if (ResultValid && rr && (ResultReg != 0)) pend_m.push_back({ResultReg, ResultData});
    @(posedge clk);
    #1;
    chk("WriteEnable", 32'(WriteEnable), 32'(we_m));
    chk("WriteRegister", 32'(WriteRegister), 32'(wr_m));
    chk("WriteData", WriteData, wd_m);
  endtask

  task automatic idle_inputs();
    IssueValid  = 1'b0;
    ResultValid = 1'b0;
  endtask

  initial begin
    model_reset();

    // Reset state
    #2;
    chk("rst_issue_ready", 32'(IssueReady), 32'd1);
    chk("rst_result_ready", 32'(ResultReady), 32'd1);
    chk("rst_hazard", 32'(Hazard), 32'd0);
    chk("rst_we", 32'(WriteEnable), 32'd0);
    chk("rst_wreg", 32'(WriteRegister), 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    #1 reset = 1'b0;

    // Issue r5, result r5 one cycle later, hazard until the write pulse
    CheckReg1  = 5'd5;
    IssueValid = 1'b1;
    IssueReg   = 5'd5;
    cycle();
    IssueValid  = 1'b0;
    ResultValid = 1'b1;
    ResultReg   = 5'd5;
    ResultData  = 32'hDEADBEEF;
    #1 chk("r5_hazard_issued", 32'(Hazard), 32'd1);
    cycle();
    ResultValid = 1'b0;
    chk("r5_hazard_queued", 32'(Hazard), 32'd1);
    chk("r5_no_write_yet", 32'(WriteEnable), 32'd0);
    cycle();
    chk("r5_we", 32'(WriteEnable), 32'd1);
    chk("r5_wreg", 32'(WriteRegister), 32'd5);
    chk("r5_wdata", WriteData, 32'hDEADBEEF);
    chk("r5_hazard_cleared", 32'(Hazard), 32'd0);
    cycle();
    chk("r5_single_pulse", 32'(WriteEnable), 32'd0);

    // Five results back-to-back
    for (int i = 0; i < 5; i++) begin
      data_v[i]   = $urandom;
      ResultValid = 1'b1;
      ResultReg   = 5'(i + 1);
      ResultData  = data_v[i];
      cycle();
      if (i > 0) begin
        chk("b2b_we", 32'(WriteEnable), 32'd1);
        chk("b2b_wreg", 32'(WriteRegister), 32'(i));
        chk("b2b_wdata", WriteData, data_v[i-1]);
      end
    end
    ResultValid = 1'b0;
    cycle();
    chk("b2b_last_wreg", 32'(WriteRegister), 32'd5);
    chk("b2b_last_wdata", WriteData, data_v[4]);
    cycle();

    // Saturating counter on r7 and issue/retire cancellation
    IssueValid = 1'b1;
    IssueReg   = 5'd7;
    repeat (3) cycle();
    IssueValid = 1'b0;
    #1 chk("r7_saturated", 32'(IssueReady), 32'd0);
    IssueReg = 5'd8;
    #1 chk("r8_ready", 32'(IssueReady), 32'd1);
    IssueReg    = 5'd7;
    IssueValid  = 1'b1;
    ResultValid = 1'b1;
    ResultReg   = 5'd7;
    ResultData  = $urandom;
    cycle();
    ResultValid = 1'b0;
    cycle();
    IssueValid = 1'b0;
    chk("r7_after_retire", 32'(IssueReady), 32'd1);
    ResultValid = 1'b1;
    ResultData  = $urandom;
    cycle();
    ResultValid = 1'b0;
    IssueValid  = 1'b1;
    cycle();
    IssueValid = 1'b0;
    chk("r7_cancel_ready", 32'(IssueReady), 32'd1);
    IssueValid = 1'b1;
    cycle();
    IssueValid = 1'b0;
    chk("r7_full_again", 32'(IssueReady), 32'd0);

    // Register 0 results and issues
    ResultValid = 1'b1;
    ResultReg   = 5'd0;
    ResultData  = 32'h1234;
    cycle();
    ResultValid = 1'b0;
    cycle();
    chk("r0_no_write", 32'(WriteEnable), 32'd0);
    cycle();
    chk("r0_no_write_late", 32'(WriteEnable), 32'd0);
    IssueValid = 1'b1;
    IssueReg   = 5'd0;
    CheckReg1  = 5'd0;
    CheckReg2  = 5'd0;
    cycle();
    IssueValid = 1'b0;
    #1 chk("r0_no_hazard", 32'(Hazard), 32'd0);

    // Back-to-back results, then reset mid-cycle
    for (int i = 0; i < DEPTH; i++) begin
      ResultValid = 1'b1;
      ResultReg   = 5'(9 + i);
      ResultData  = $urandom;
      cycle();
    end
    ResultValid = 1'b0;
    IssueReg    = 5'd7;
    CheckReg1   = 5'd7;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(WriteEnable), 32'd0);
    chk("mid_rst_wreg", 32'(WriteRegister), 32'd0);
    chk("mid_rst_wdata", WriteData, 32'd0);
    chk("mid_rst_issue_ready", 32'(IssueReady), 32'd1);
    chk("mid_rst_result_ready", 32'(ResultReady), 32'd1);
    chk("mid_rst_hazard", 32'(Hazard), 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_no_write", 32'(WriteEnable), 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      IssueValid  = 1'($urandom_range(0, 1));
      IssueReg    = 5'($urandom_range(0, 7));
      ResultValid = 1'($urandom_range(0, 1));
      ResultReg   = 5'($urandom_range(0, 7));
      ResultData  = $urandom;
      CheckReg1   = 5'($urandom_range(0, 7));
      CheckReg2   = 5'($urandom_range(0, 7));
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
